// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel packet-aware arbiter/multiplexer with a single
// registered output slot. Arbitration is round-robin or fixed priority
// (lowest index), selected by `mode` while idle; once a multi-beat packet
// starts, the grant stays on that channel until its last beat is accepted.
module arb_mux_rr #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned N     = 3,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [SW-1:0]    r_lock_ch;
  logic             r_lock_rr;   // packet was won under round-robin
  logic [SW-1:0]    r_ptr;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SW-1:0]    r_out_sel;

  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_idx;
  int unsigned      w_rr_idx;
  logic             w_slot_free;
  logic             w_load;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;
  logic [SW-1:0]    w_ptr_next;

  // Grant selection: locked channel, fixed priority, or round-robin from r_ptr
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_rr_idx  = 0;
    if (r_state == ST_LOCKED) begin
      w_gnt_vld = in_valid[r_lock_ch];
      w_gnt_idx = r_lock_ch;
    end else if (mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!w_gnt_vld && in_valid[SW'(i)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        w_rr_idx = 32'(r_ptr) + k;
        if (w_rr_idx >= N) begin
          w_rr_idx = w_rr_idx - N;
        end
        if (!w_gnt_vld && in_valid[SW'(w_rr_idx)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SW'(w_rr_idx);
        end
      end
    end
  end

  // Only the granted channel's data and last flag reach the output slot
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt_idx == SW'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
        w_sel_last = in_last[i];
      end
    end
  end

  // Handshake: slot accepts when empty or draining; ready held low in reset
  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_load      = rst_n && w_gnt_vld && w_slot_free;
    w_ptr_next  = (w_gnt_idx == SW'(N - 1)) ? '0 : w_gnt_idx + SW'(1);
    in_ready    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = w_load && (w_gnt_idx == SW'(i));
    end
  end

  // Output slot register: load on accept, drop valid when drained with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_sel   <= w_gnt_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet lock FSM and round-robin pointer; the pointer only advances at the
  // end of a packet that was won by round-robin, so a mode change while
  // locked does not disturb it until the next idle arbitration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lock_ch <= '0;
      r_lock_rr <= 1'b0;
      r_ptr     <= '0;
    end else if (w_load) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_sel_last) begin
            r_state   <= ST_LOCKED;
            r_lock_ch <= w_gnt_idx;
            r_lock_rr <= !mode;
          end else if (!mode) begin
            r_ptr <= w_ptr_next;
          end
        end
        ST_LOCKED: begin
          if (w_sel_last) begin
            r_state <= ST_IDLE;
            if (r_lock_rr) begin
              r_ptr <= w_ptr_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_rr.sv
// Directed bench for arb_mux_rr. Each step drives one cycle of inputs with a
// hand-computed expected grant; the granted beat is queued and a monitor
// compares it when it shows up on the output slot.
module tb_arb_mux_rr;
  localparam int unsigned WIDTH = 18;
  localparam int unsigned N     = 3;
  localparam int unsigned SW    = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic [SW-1:0]      out_sel;
  logic               out_ready;

  always #5 clk = ~clk;

  arb_mux_rr #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic [SW-1:0]    s;
    logic             l;
  } beat_t;

  beat_t q[$];
  beat_t last_push;
  int    errors = 0;
  int    checks = 0;
  int    step_no = 0;

  function automatic logic [WIDTH-1:0] dat(input int s, input int ch);
    return WIDTH'(32'h1000 + s * 16 + ch);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // One cycle: drive at posedge+1, check in_ready at negedge, queue the beat
  task automatic step(input logic [2:0] v, input logic [2:0] l, input logic m,
                      input logic ordy, input int g);
    logic [N-1:0] exp_rdy;
    beat_t        b;
    @(posedge clk);
    #1;
    step_no++;
    for (int i = 0; i < int'(N); i++) in_data[i*WIDTH +: WIDTH] = dat(step_no, i);
    in_valid  = v;
    in_last   = l;
    mode      = m;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (g < 0) ? 3'b000 : (3'b001 << g);
    chk($sformatf("in_ready step %0d", step_no), 32'(in_ready), 32'(exp_rdy));
    if (g >= 0) begin
      b.d = dat(step_no, g);
      b.s = SW'(g);
      b.l = l[g];
      q.push_back(b);
      last_push = b;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 3'b111;
    in_last   = 3'b111;
    mode      = 1'b0;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL out_beat: unexpected beat data=%h sel=%0d last=%b, want none",
                     out_data, out_sel, out_last);
          end else begin
            if ({out_data, out_sel, out_last} !== q[0]) begin
              errors++;
              $display("FAIL out_beat: got data=%h sel=%0d last=%b, want data=%h sel=%0d last=%b",
                       out_data, out_sel, out_last, q[0].d, q[0].s, q[0].l);
            end
            if (out_ready === 1'b1) void'(q.pop_front());
          end
        end
      end
    join_none

    // Reset state, with inputs valid to show in_ready is held low
    #3;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data",  32'(out_data),  0);
    chk("rst out_sel",   32'(out_sel),   0);
    chk("rst out_last",  32'(out_last),  0);
    chk("rst in_ready",  32'(in_ready),  0);
    in_valid = '0;
    in_last  = '0;
    #19;
    rst_n = 1'b1;

    // Round-robin, all single-beat: 0,1,2,0,1,2
    step(3'b111, 3'b111, 1'b0, 1'b1, 0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 1);
    step(3'b111, 3'b111, 1'b0, 1'b1, 2);
    step(3'b111, 3'b111, 1'b0, 1'b1, 0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 1);
    step(3'b111, 3'b111, 1'b0, 1'b1, 2);
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);
    // Slot drained: valid drops, sel/data hold
    @(negedge clk);
    chk("drain out_valid", 32'(out_valid), 0);
    chk("drain out_sel",   32'(out_sel),   2);
    chk("drain out_data",  32'(out_data),  32'(last_push.d));

    // Fixed priority: 110 -> 1, then 0 wins while valid, ch2 starved
    step(3'b110, 3'b111, 1'b1, 1'b1, 1);
    step(3'b111, 3'b111, 1'b1, 1'b1, 0);
    step(3'b111, 3'b111, 1'b1, 1'b1, 0);
    step(3'b110, 3'b111, 1'b1, 1'b1, 1);
    step(3'b000, 3'b000, 1'b1, 1'b1, -1);

    // Lock: ch0 single (ptr->1), ch1 3-beat packet with ch0 waiting
    step(3'b001, 3'b001, 1'b0, 1'b1, 0);
    step(3'b011, 3'b000, 1'b0, 1'b1, 1);
    step(3'b011, 3'b000, 1'b0, 1'b1, 1);
    step(3'b001, 3'b000, 1'b0, 1'b1, -1);   // locked channel idle: no grant
    step(3'b011, 3'b010, 1'b0, 1'b1, 1);    // last beat, ptr->2
    step(3'b001, 3'b001, 1'b0, 1'b1, 0);    // ptr->1
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);

    // Backpressure: 4 stalled cycles, no loss or duplication
    step(3'b111, 3'b111, 1'b0, 1'b1, 1);    // ptr->2
    step(3'b111, 3'b111, 1'b0, 1'b0, -1);
    step(3'b111, 3'b111, 1'b0, 1'b0, -1);
    step(3'b111, 3'b111, 1'b0, 1'b0, -1);
    step(3'b111, 3'b111, 1'b0, 1'b0, -1);
    step(3'b111, 3'b111, 1'b0, 1'b1, 2);    // ptr->0
    step(3'b111, 3'b111, 1'b0, 1'b1, 0);    // ptr->1
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);

    // Mode toggled during lock on ch2; next arbitration is fixed priority
    step(3'b100, 3'b000, 1'b0, 1'b1, 2);
    step(3'b111, 3'b000, 1'b1, 1'b1, 2);
    step(3'b111, 3'b100, 1'b1, 1'b1, 2);    // lock ends, ptr->0
    step(3'b110, 3'b111, 1'b1, 1'b1, 1);
    step(3'b111, 3'b111, 1'b1, 1'b1, 0);
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);

    // Reset mid-packet, locked on ch2 with ptr=2
    step(3'b010, 3'b010, 1'b0, 1'b1, 1);    // ptr->2
    step(3'b111, 3'b000, 1'b0, 1'b1, 2);
    step(3'b111, 3'b000, 1'b0, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 0);
    chk("midrst out_sel",   32'(out_sel),   0);
    chk("midrst out_data",  32'(out_data),  0);
    chk("midrst in_ready",  32'(in_ready),  0);
    in_valid = '0;
    in_last  = '0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(3'b111, 3'b111, 1'b0, 1'b1, 0);
    step(3'b111, 3'b111, 1'b0, 1'b1, 1);
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);
    step(3'b000, 3'b000, 1'b0, 1'b1, -1);
    @(negedge clk);
    chk("queue drained", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit in case the clock or a step stalls
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/arb_mux_rr.md
ARB_MUX_RR -- requirements
Module: arb_mux_rr

Interface
REQ-001 Parameter WIDTH, default 18, data bits per channel.
REQ-002 Parameter N, default 3, number of input channels (2..16).
REQ-003 Parameter SW, default $clog2(N), channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel beat valid.
REQ-008 in_last  input  N  per-channel last beat of packet.
REQ-009 in_ready  output  N  per-channel beat accepted when in_valid[i] && in_ready[i].
REQ-010 mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_valid  output  1  out_data holds a beat.
REQ-013 out_last  output  1  registered in_last of the held beat.
REQ-014 out_sel  output  SW  registered index of the channel that supplied the held beat.
REQ-015 out_ready  input  1  downstream accepts when out_valid && out_ready.

Function
REQ-016 Output stage is one register slot; slot loads when (!out_valid || out_ready) and a grant exists.
REQ-017 At most one in_ready bit is high per cycle; in_ready[i] = grant[i] && (!out_valid || out_ready), combinational.
REQ-018 Latency: beat accepted in cycle t appears on out_* in cycle t+1; sustained throughput one beat per cycle with out_ready held high.
REQ-019 If slot empties (out_ready, no grant), out_valid drops to 0 next cycle; out_data/out_sel/out_last hold last value.
REQ-020 State machine: IDLE, LOCKED.
REQ-021 IDLE: grant chosen by arbitration among in_valid; accepted beat with in_last=0 -> LOCKED on that channel; in_last=1 -> stay IDLE.
REQ-022 LOCKED: grant fixed to locked channel regardless of other in_valid or mode; other channels see in_ready=0; accepted beat with in_last=1 -> IDLE.
REQ-023 LOCKED with locked channel in_valid=0: no grant, no transfer, remain LOCKED.
REQ-024 Round-robin: pointer ptr (SW bits); search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first valid wins.
REQ-025 ptr updates to (granted index + 1) mod N only on an accepted beat with in_last=1; wrap from N-1 to 0.
REQ-026 Fixed priority: lowest valid index wins; ptr not updated.
REQ-027 mode sampled only in IDLE; a mode change during LOCKED takes effect at the first arbitration after return to IDLE.
REQ-028 No in_valid: no grant, all in_ready=0, state unchanged.
REQ-029 Simultaneous output drain and input accept in one cycle: new beat replaces old, out_valid stays 1.
REQ-030 in_data of non-granted channels never reaches out_data.

Reset
REQ-031 rst_n low asynchronously forces: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, state IDLE; in_ready=0 while rst_n low.
REQ-032 Reset mid-packet discards the held beat and the lock; first cycle after release arbitrates from ptr=0.
REQ-033 No transfer occurs in the cycle rst_n deasserts unless inputs valid at that edge and slot empty (normal rules).

Verification
REQ-034 N=3, mode=0, all valid, all in_last=1, out_ready=1 -> out_sel sequence 0,1,2,0,1,2; one beat per cycle.
REQ-035 mode=1, in_valid=3'b110 then 3'b111 -> out_sel 1 then 0; channel 2 starved while 0 or 1 valid.
REQ-036 Channel 1 sends 3-beat packet (last on beat 3), channel 0 valid throughout -> out_sel 1,1,1 then 0; in_ready[0]=0 during lock.
REQ-037 out_ready=0 for 4 cycles with valid inputs -> out_data/out_sel stable, all in_ready=0; on out_ready=1 resumes with no loss or duplication.
REQ-038 Assert rst_n low mid-packet (LOCKED on ch 2, ptr=2) -> out_valid=0 immediately; after release all valid -> first out_sel=0.
REQ-039 Toggle mode 0->1 while LOCKED on ch 2 -> lock completes on ch 2; next arbitration fixed-priority, selects lowest valid index.
